// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer datapath: sequencer state encoding,
// default layer geometry and a width helper.
package nn_pkg;

  // Sequencer states; encoding is visible to debug tooling, so keep it fixed.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StWaitOut = 2'd2,
    StFinish  = 2'd3
  } nn_state_e;

  // Default layer geometry, shared with the accumulator and weight ROM.
  localparam int unsigned NnInputs     = 16;
  localparam int unsigned NnNeurons    = 4;
  localparam int unsigned NnStepCycles = 3;

  // $clog2 that never returns 0, so single-entry counters still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/nn_step_timer.sv
// Phase counter for one MAC step: counts 0..STEP_CYCLES-1 and wraps.
// hold_i freezes the count, clr_i forces it back to 0, tc_o flags the last
// phase of a step.
module nn_step_timer
  import nn_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = NnStepCycles,
  parameter int unsigned PH_W        = clog2_min1(STEP_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic hold_i,
  output logic tc_o
);

  localparam logic [PH_W-1:0] PhLast = PH_W'(STEP_CYCLES - 1);

  logic [PH_W-1:0] phase_d, phase_q;

  // Next phase: clear has priority over hold; with STEP_CYCLES=1 it stays 0.
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (!hold_i) begin
      phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tc_o = (phase_q == PhLast);

endmodule

// File: rtl/nn_layer_seq.sv
// Dense-layer sequencer: walks one shared MAC datapath over N_NEURONS outputs
// of N_INPUTS inputs each, STEP_CYCLES clocks per MAC step, and hands each
// finished neuron to the consumer over a valid/ready handshake.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS    = NnInputs,
  parameter int unsigned N_NEURONS   = NnNeurons,
  parameter int unsigned STEP_CYCLES = NnStepCycles,
  parameter int unsigned IDX_W       = $clog2(N_INPUTS),
  parameter int unsigned NRN_W       = clog2_min1(N_NEURONS),
  parameter int unsigned WADDR_W     = $clog2(N_INPUTS * N_NEURONS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic [IDX_W-1:0]   in_idx_o,
  output logic [NRN_W-1:0]   neuron_idx_o,
  output logic [WADDR_W-1:0] w_addr_o,
  output logic               bias_sel_o,
  output logic               mac_step_o,
  output logic               out_valid_o,
  output logic               done_o
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_INPUTS - 1);
  localparam logic [NRN_W-1:0] NrnLast = NRN_W'(N_NEURONS - 1);

  nn_state_e        state_d, state_q;
  logic [IDX_W-1:0] in_idx_d, in_idx_q;
  logic [NRN_W-1:0] nrn_d, nrn_q;
  logic             run;
  logic             step_tc;
  logic             mac_step;

  assign run = (state_q == StRun);

  // Phase only advances in RUN; every other state parks it at 0 so each
  // neuron (and each layer) starts on a fresh step boundary.
  nn_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!run),
    .hold_i (stall_i),
    .tc_o   (step_tc)
  );

  // Stall wins over the terminal phase; the step retries next cycle.
  assign mac_step = run && step_tc && !stall_i;

  // Next-state and index update.
  always_comb begin
    state_d  = state_q;
    in_idx_d = in_idx_q;
    nrn_d    = nrn_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          in_idx_d = '0;
          nrn_d    = '0;
        end
      end
      StRun: begin
        if (mac_step) begin
          if (in_idx_q == IdxLast) begin
            state_d = StWaitOut;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      StWaitOut: begin
        if (out_ready_i) begin
          if (nrn_q == NrnLast) begin
            state_d = StFinish;
          end else begin
            state_d  = StRun;
            in_idx_d = '0;
            nrn_d    = nrn_q + 1'b1;
          end
        end
      end
      StFinish: begin
        state_d  = StIdle;
        in_idx_d = '0;
        nrn_d    = '0;
      end
      default: begin
        state_d  = StIdle;
        in_idx_d = '0;
        nrn_d    = '0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      in_idx_q <= '0;
      nrn_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_idx_q <= in_idx_d;
      nrn_q    <= nrn_d;
    end
  end

  // Outputs are decoded from registered state, so out_valid/done/busy are
  // glitch-free; only mac_step sees the live stall input.
  assign busy_o       = (state_q != StIdle);
  assign out_valid_o  = (state_q == StWaitOut);
  assign done_o       = (state_q == StFinish);
  assign bias_sel_o   = run && (in_idx_q == '0);
  assign mac_step_o   = mac_step;
  assign in_idx_o     = in_idx_q;
  assign neuron_idx_o = nrn_q;
  assign w_addr_o     = WADDR_W'(32'(nrn_q) * N_INPUTS + 32'(in_idx_q));

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: scoreboard of expected MAC steps, handshakes and
// done pulses (with expected cycles) checked by a negedge monitor, plus a
// second instance with STEP_CYCLES=1 and a single neuron.
module tb_nn_layer_seq;

  localparam int unsigned NI = 16;
  localparam int unsigned NN = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned NoAddr = 9999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       out_ready = 1'b1;
  logic       busy, bias_sel, mac_step, out_valid, done;
  logic [3:0] in_idx;
  logic [1:0] neuron_idx;
  logic [5:0] w_addr;

  logic       start2 = 1'b0;
  logic       stall2 = 1'b0;
  logic       out_ready2 = 1'b1;
  logic       busy2, bias_sel2, mac_step2, out_valid2, done2;
  logic [3:0] in_idx2;
  logic [0:0] neuron_idx2;
  logic [3:0] w_addr2;

  always #5 clk = ~clk;

  nn_layer_seq #(
    .N_INPUTS    (NI),
    .N_NEURONS   (NN),
    .STEP_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .stall_i      (stall),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .in_idx_o     (in_idx),
    .neuron_idx_o (neuron_idx),
    .w_addr_o     (w_addr),
    .bias_sel_o   (bias_sel),
    .mac_step_o   (mac_step),
    .out_valid_o  (out_valid),
    .done_o       (done)
  );

  nn_layer_seq #(
    .N_INPUTS    (16),
    .N_NEURONS   (1),
    .STEP_CYCLES (1)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start2),
    .stall_i      (stall2),
    .out_ready_i  (out_ready2),
    .busy_o       (busy2),
    .in_idx_o     (in_idx2),
    .neuron_idx_o (neuron_idx2),
    .w_addr_o     (w_addr2),
    .bias_sel_o   (bias_sel2),
    .mac_step_o   (mac_step2),
    .out_valid_o  (out_valid2),
    .done_o       (done2)
  );

  typedef struct {
    int unsigned addr;
    int unsigned bias;
    int unsigned cyc;
  } mac_exp_t;

  mac_exp_t    mac_q[$];
  int unsigned hs_nrn_q[$];
  int unsigned hs_cyc_q[$];
  int unsigned done_cyc_q[$];
  mac_exp_t    m_exp;
  int unsigned exp_v;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned mac_cnt = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Expected event timeline of one layer started in cycle c0.
  task automatic push_layer(input int unsigned c0, input int unsigned stall_addr,
                            input int unsigned stall_len, input int unsigned rdy_len);
    int unsigned t;
    int unsigned a;
    t = c0;
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) begin
        t += SC;
        a = n * NI + i;
        if (a == stall_addr) t += stall_len;
        mac_q.push_back('{addr: a, bias: (i == 0) ? 1 : 0, cyc: t});
      end
      t += 1;
      if (n == 0) t += rdy_len;
      hs_nrn_q.push_back(n);
      hs_cyc_q.push_back(t);
    end
    done_cyc_q.push_back(t + 1);
  endtask

  task automatic flush_sb();
    mac_q.delete();
    hs_nrn_q.delete();
    hs_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  // Monitor: every observed event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bias_sel) check_eq("bias_only_idx0", in_idx, 0);
      if (mac_step) begin
        mac_cnt++;
        if (mac_q.size() == 0) begin
          check_eq("mac_unexpected", 1, 0);
        end else begin
          m_exp = mac_q.pop_front();
          check_eq("mac_waddr", w_addr, m_exp.addr);
          check_eq("mac_bias", bias_sel, m_exp.bias);
          check_eq("mac_cycle", cyc, m_exp.cyc);
        end
      end
      if (out_valid && out_ready) begin
        if (hs_nrn_q.size() == 0) begin
          check_eq("hs_unexpected", 1, 0);
        end else begin
          exp_v = hs_nrn_q.pop_front();
          check_eq("hs_neuron", neuron_idx, exp_v);
          exp_v = hs_cyc_q.pop_front();
          check_eq("hs_cycle", cyc, exp_v);
        end
      end
      if (done) begin
        if (done_cyc_q.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          exp_v = done_cyc_q.pop_front();
          check_eq("done_cycle", cyc, exp_v);
          check_eq("mac_count", mac_cnt, NI * NN);
        end
      end
    end
  end

  task automatic run_layer(input int unsigned stall_len, input int unsigned rdy_len,
                           input bit busy_start);
    bit stall_done, rdy_done, sb_done, finished;
    stall_done = 0;
    rdy_done = 0;
    sb_done = 0;
    finished = 0;
    mac_cnt = 0;
    push_layer(cyc, (stall_len > 0) ? 39 : NoAddr, stall_len, rdy_len);
    out_ready = (rdy_len == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    for (int k = 0; k < 600 && !finished; k++) begin
      if (rdy_len > 0 && !rdy_done && out_valid) begin
        rdy_done = 1;
        for (int j = 0; j < rdy_len; j++) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_in_idx", in_idx, 15);
          check_eq("hold_neuron", neuron_idx, 0);
          check_eq("hold_no_mac", mac_step, 0);
          tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("resume_neuron", neuron_idx, 1);
        check_eq("resume_waddr", w_addr, 16);
        check_eq("resume_busy", busy, 1);
      end
      if (stall_len > 0 && !stall_done && w_addr == 39) begin
        stall_done = 1;
        stall = 1'b1;
        for (int j = 0; j < stall_len; j++) begin
          #1;
          check_eq("stall_waddr", w_addr, 39);
          check_eq("stall_no_mac", mac_step, 0);
          tick();
        end
        stall = 1'b0;
      end
      if (busy_start && !sb_done && neuron_idx == 1 && in_idx == 3) begin
        sb_done = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (!busy) finished = 1;
      else tick();
    end
    check_eq("layer_finished", finished, 1);
    check_eq("mac_q_drained", mac_q.size(), 0);
    check_eq("hs_q_drained", hs_nrn_q.size(), 0);
    check_eq("done_q_drained", done_cyc_q.size(), 0);
    flush_sb();
    out_ready = 1'b1;
  endtask

  initial begin
    bit          found;
    int unsigned m2;
    int unsigned d2;

    repeat (3) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_mac", mac_step, 0);
    check_eq("rst_bias", bias_sel, 0);
    check_eq("rst_in_idx", in_idx, 0);
    check_eq("rst_neuron", neuron_idx, 0);
    check_eq("rst_waddr", w_addr, 0);
    rst = 1'b0;
    tick();
    check_eq("idle_busy", busy, 0);

    // Plain layer, then back-pressure, then stall.
    run_layer(0, 0, 0);
    tick();
    run_layer(0, 10, 0);
    tick();
    run_layer(5, 0, 0);
    tick();

    // Reset during WAIT_OUT of neuron 1.
    mac_cnt = 0;
    push_layer(cyc, NoAddr, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (out_valid && neuron_idx == 1) found = 1;
      else tick();
    end
    check_eq("reach_wait_n1", found, 1);
    rst = 1'b1;
    flush_sb();
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_in_idx", in_idx, 0);
    check_eq("midrst_neuron", neuron_idx, 0);
    tick();
    check_eq("midrst_busy_next", busy, 0);
    check_eq("midrst_valid_next", out_valid, 0);
    rst = 1'b0;
    repeat (5) tick();
    check_eq("after_rst_idle", busy, 0);
    run_layer(0, 0, 0);
    tick();

    // start pulsed while busy must not disturb the sequence.
    run_layer(0, 0, 1);
    tick();

    // STEP_CYCLES=1, single neuron: 16 back-to-back steps, valid, done.
    m2 = 0;
    d2 = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (mac_step2) m2++;
      if (done2) d2++;
      if (k <= 16) begin
        check_eq("s1_mac", mac_step2, 1);
        check_eq("s1_waddr", w_addr2, k - 1);
        check_eq("s1_bias", bias_sel2, (k == 1) ? 1 : 0);
      end else if (k == 17) begin
        check_eq("s1_valid", out_valid2, 1);
        check_eq("s1_no_mac", mac_step2, 0);
      end else begin
        check_eq("s1_done", done2, 1);
      end
      tick();
    end
    check_eq("s1_mac_count", m2, 16);
    check_eq("s1_done_count", d2, 1);
    check_eq("s1_idle", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
Sequences one shared multiply-accumulate datapath across a full dense layer of N_NEURONS outputs. Each output takes N_INPUTS inputs, and each MAC step lasts STEP_CYCLES clocks.
- Generates input index, weight address, bias-select and accumulate strobe.
- Presents each finished neuron on a valid/ready output handshake.
- Sits between the top-level layer control (start/done) and the accumulator/MAC/weight ROM.

Parameters:
N_INPUTS, 16, inputs per neuron (>=2)
N_NEURONS, 4, neurons per layer (>=1)
STEP_CYCLES, 3, clocks per MAC step (>=1)
IDX_W, $clog2(N_INPUTS), input index width
NRN_W, $clog2(N_NEURONS) (min 1), neuron index width
WADDR_W, $clog2(N_INPUTS*N_NEURONS), weight address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin layer; sampled only in IDLE
stall  in  1  freeze step progress while high (RUN only)
busy  out  1  high in every state except IDLE
in_idx  out  IDX_W  current input index
neuron_idx  out  NRN_W  current neuron
w_addr  out  WADDR_W  neuron_idx*N_INPUTS + in_idx
bias_sel  out  1  accumulator adds bias this step
mac_step  out  1  one-clock strobe; accumulator captures on it
out_valid  out  1  neuron result ready in accumulator
out_ready  in  1  consumer accepts result
done  out  1  one-clock pulse after last neuron accepted

Behaviour:
- Reset (async): state=IDLE, phase=0, in_idx=0, neuron_idx=0. All outputs are 0.
- States: IDLE, RUN, WAIT_OUT, FINISH.
- IDLE:
  - start=1 -> RUN next cycle with phase=0, in_idx=0, neuron_idx=0.
  - start is ignored in all other states.
- RUN:
  - phase counts 0..STEP_CYCLES-1 and wraps to 0.
  - mac_step = (phase==STEP_CYCLES-1) && !stall, combinational from registered state.
  - stall=1 holds phase, in_idx and neuron_idx, and suppresses mac_step.
  - On mac_step with in_idx<N_INPUTS-1: in_idx+1.
  - On mac_step with in_idx==N_INPUTS-1: go to WAIT_OUT; in_idx holds at N_INPUTS-1.
  - bias_sel = 1 throughout RUN while in_idx==0; 0 otherwise.
- WAIT_OUT:
  - out_valid=1, registered, asserted on the first WAIT_OUT cycle. mac_step=0.
  - out_valid stays high until out_ready=1; no timeout.
  - Handshake (out_valid && out_ready) with neuron_idx<N_NEURONS-1: neuron_idx+1, in_idx=0, phase=0, return to RUN.
  - Handshake with neuron_idx==N_NEURONS-1: go to FINISH.
  - out_ready is ignored outside WAIT_OUT.
- FINISH:
  - done=1 for exactly one cycle, then IDLE.
  - Indices reset to 0 on entering IDLE.
- Timing:
  - Start sampled at edge k: first mac_step is high in the cycle before edge k+STEP_CYCLES.
  - Per neuron, with no stall: N_INPUTS*STEP_CYCLES RUN cycles, plus at least 1 WAIT_OUT cycle.
  - Whole layer with out_ready tied high: N_NEURONS*(N_INPUTS*STEP_CYCLES+1)+1 cycles from start to the done pulse. Default = 197.
- w_addr is always consistent with the registered in_idx/neuron_idx; it is not reset-sensitive beyond those indices.
- Reset mid-operation (any state): immediate return to IDLE with all outputs 0. No done pulse, no out_valid.
- Simultaneous stall and phase==STEP_CYCLES-1: the stall wins and the step retries next cycle.
- STEP_CYCLES=1: phase is a constant 0, and mac_step is high every non-stalled RUN cycle.

Decomposition:
- Shared package nn_pkg holds:
  - the state enum encoding (IDLE=0, RUN=1, WAIT_OUT=2, FINISH=3);
  - default N_INPUTS/N_NEURONS/STEP_CYCLES constants, shared with the accumulator and weight ROM.
- One sub-module, nn_step_timer: phase counter with a hold input and terminal-count output. It is reusable by other accumulator controllers.
- The index counters and FSM stay in nn_layer_seq.

Test Plan:
- Defaults, out_ready=1, pulse start at cycle 0:
  - mac_step fires 64 times per layer, every 3rd cycle;
  - bias_sel is high only for in_idx=0 steps;
  - w_addr runs 0..63 in order;
  - done pulses exactly once, 197 cycles after start.
- Hold out_ready=0 for 10 cycles after the first out_valid: out_valid stays high, indices stay frozen at in_idx=15/neuron_idx=0, and no mac_step occurs. Raising out_ready resumes RUN with neuron_idx=1 and w_addr=16.
- Assert stall for 5 cycles during neuron 2, in_idx=7: phase and w_addr hold at 39 and mac_step stays 0. Total layer time grows by exactly 5 cycles.
- Assert rst during WAIT_OUT of neuron 1: next cycle busy=0, out_valid=0, indices 0, and no done. A following start runs a full, correct layer.
- Pulse start while busy at neuron 1: it is ignored and the sequence is unchanged. Separately, STEP_CYCLES=1 with N_NEURONS=1: 16 consecutive mac_step cycles, then out_valid, then done.
